// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//   Inter-stage pipeline register with a valid/ready handshake, a synchronous
//   flush, and an optional two-entry skid buffer. The payload is an opaque bus.
//   The instantiating stage packs its own fields into it.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
//   both 1 on that side (in_fire = in_valid & in_ready,
//   out_fire = out_valid & out_ready). A producer keeps valid and data stable
//   until the transfer happens. in_valid may not depend on in_ready.
//
// Parameters
//   WIDTH       payload width (>= 1)
//   SKID        1: two entries, registered in_ready; 0: one entry, comb in_ready
//   ZERO_BUBBLE 1: out_data reads zero whenever the block is empty
//   CNT_W       stall counter width
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous kill of all held entries
//   in_valid/in_ready/in_data     upstream side
//   out_valid/out_ready/out_data  downstream side (out_data registered)
//   occupancy         held entries (0..2); this is also the FSM state
//   stall_cnt         saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int WIDTH       = 32,
    parameter int SKID        = 1,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // The encoding equals the number of held entries, so occupancy is the
    // state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] skid_nxt;
    logic             skid_valid;
    logic             in_fire;
    logic             out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_data;
    assign occupancy = state;

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_nxt;
            skid_data <= skid_nxt;
        end
    end

    // Next-state and payload steering. flush overrides every transfer.
    // An input accepted in the flush cycle is dropped.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_data;
        skid_nxt  = skid_data;
        if (flush) begin
            state_nxt = EMPTY;
            if (ZERO_BUBBLE != 0) main_nxt = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        // The downstream stage is stalled, so the new payload
                        // goes into the skid entry behind the current one.
                        state_nxt = FULL;
                        skid_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                        if (ZERO_BUBBLE != 0) main_nxt = '0;
                    end
                end
                FULL: begin
                    // in_ready is 0 in FULL, so only the drain case applies.
                    if (out_fire) begin
                        state_nxt = ONE;
                        main_nxt  = skid_data;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Outputs decoded from the state register. With SKID=1, in_ready comes
    // from state only, so no path exists from out_ready to in_ready.
    always_comb begin
        out_valid  = (state != EMPTY);
        skid_valid = (state == FULL);
        if (SKID != 0) in_ready = !skid_valid;
        else           in_ready = !out_valid || out_ready;
    end

    // Stall counter. It saturates at all-ones and flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Directed bench for two configurations of pipe_stage_buf:
//     dut_a: SKID=1, ZERO_BUBBLE=1, CNT_W=4
//     dut_b: SKID=0, ZERO_BUBBLE=0, CNT_W=16
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int W = 8;

    // ---- clock / reset ----
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---- dut_a signals ----
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic [3:0]   a_stall;

    // ---- dut_b signals ----
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
    logic [15:0]  b_stall;

    pipe_stage_buf #(.WIDTH(W), .SKID(1), .ZERO_BUBBLE(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_buf #(.WIDTH(W), .SKID(0), .ZERO_BUBBLE(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    // ---- scoreboard ----
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---- driver tasks ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = r;
        a_flush     = f;
    endtask

    task automatic drive_b(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        b_in_valid  = v;
        b_in_data   = d;
        b_out_ready = r;
        b_flush     = f;
    endtask

    initial begin
        drive_a(1'b0, '0, 1'b0, 1'b0);
        drive_b(1'b0, '0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2;
        // ---- reset values ----
        check("a_rst_valid", a_out_valid, 0);
        check("a_rst_data",  a_out_data,  0);
        check("a_rst_occ",   a_occ,       0);
        check("a_rst_stall", a_stall,     0);
        check("a_rst_ready", a_in_ready,  1);
        check("b_rst_ready", b_in_ready,  1);
        check("b_rst_data",  b_out_data,  0);
        #9 rst = 1'b0;
        step();

        // ---- a: streaming 1..8 with out_ready=1 ----
        for (int i = 1; i <= 8; i++) begin
            drive_a(1'b1, W'(i), 1'b1, 1'b0);
            check("a_stream_ready", a_in_ready, 1);
            if (a_in_ready) exp_q.push_back(W'(i));
            step();
            check("a_stream_valid", a_out_valid, 1);
            check("a_stream_qlen", exp_q.size(), 1);
            if (exp_q.size() > 0) check("a_stream_data", a_out_data, exp_q.pop_front());
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        step();
        check("a_bubble_valid", a_out_valid, 0);
        check("a_bubble_data",  a_out_data,  0);
        check("a_stream_stall", a_stall,     0);

        // ---- a: skid fill ----
        drive_a(1'b1, 8'h0A, 1'b1, 1'b0);
        step();
        check("a_skid_0a", a_out_data, 8'h0A);
        drive_a(1'b1, 8'h0B, 1'b0, 1'b0);
        step();
        check("a_skid_occ2",   a_occ,      2);
        check("a_skid_ready0", a_in_ready, 0);
        check("a_skid_head",   a_out_data, 8'h0A);
        drive_a(1'b1, 8'h0C, 1'b0, 1'b0);
        step();
        check("a_skid_hold_occ",  a_occ,      2);
        check("a_skid_hold_data", a_out_data, 8'h0A);
        drive_a(1'b1, 8'h0C, 1'b1, 1'b0);
        step();
        check("a_skid_drain_0b",  a_out_data, 8'h0B);
        check("a_skid_drain_occ", a_occ,      1);
        check("a_skid_ready1",    a_in_ready, 1);
        step();
        check("a_skid_drain_0c", a_out_data, 8'h0C);
        check("a_skid_drain_v",  a_out_valid, 1);
        drive_a(1'b0, '0, 1'b1, 1'b0);
        step();
        check("a_skid_empty", a_out_valid, 0);
        check("a_skid_stall", a_stall,     2);

        // ---- a: flush in FULL with in_valid=1 ----
        drive_a(1'b1, 8'h11, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 8'h22, 1'b0, 1'b0);
        step();
        check("a_fl_full", a_occ, 2);
        check("a_fl_pre_stall", a_stall, 3);
        drive_a(1'b1, 8'h33, 1'b1, 1'b1);
        step();
        check("a_fl_valid", a_out_valid, 0);
        check("a_fl_occ",   a_occ,       0);
        check("a_fl_data",  a_out_data,  0);
        check("a_fl_stall", a_stall,     3);
        drive_a(1'b0, '0, 1'b1, 1'b0);
        step();
        check("a_fl_no_leak", a_out_valid, 0);
        // A flush with in_fire from EMPTY drops that payload.
        drive_a(1'b1, 8'h44, 1'b1, 1'b1);
        step();
        check("a_fl_drop_valid", a_out_valid, 0);
        check("a_fl_drop_data",  a_out_data,  0);

        // ---- a: stall saturation (CNT_W=4) ----
        drive_a(1'b1, 8'h66, 1'b1, 1'b0);
        step();
        drive_a(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step();
        check("a_sat_mid", a_stall, 14);
        for (int i = 0; i < 9; i++) step();
        check("a_sat_top", a_stall, 15);
        check("a_sat_data", a_out_data, 8'h66);

        // ---- a: async reset while FULL ----
        drive_a(1'b1, 8'h77, 1'b0, 1'b0);
        step();
        check("a_ar_full", a_occ, 2);
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("a_ar_valid", a_out_valid, 0);
        check("a_ar_data",  a_out_data,  0);
        check("a_ar_occ",   a_occ,       0);
        check("a_ar_stall", a_stall,     0);
        check("a_ar_ready", a_in_ready,  1);
        #2 rst = 1'b0;
        drive_a(1'b1, 8'h88, 1'b1, 1'b0);
        step();
        check("a_ar_first_v", a_out_valid, 1);
        check("a_ar_first_d", a_out_data,  8'h88);
        check("a_ar_first_o", a_occ,       1);
        drive_a(1'b0, '0, 1'b1, 1'b0);
        step();

        // ---- b: streaming, SKID=0 ----
        for (int i = 1; i <= 4; i++) begin
            drive_b(1'b1, W'(i), 1'b1, 1'b0);
            step();
            check("b_stream_data", b_out_data, i);
            check("b_stream_valid", b_out_valid, 1);
        end
        // ---- b: bubble with ZERO_BUBBLE=0 ----
        drive_b(1'b1, 8'h55, 1'b1, 1'b0);
        step();
        check("b_bub_55", b_out_data, 8'h55);
        drive_b(1'b0, '0, 1'b1, 1'b0);
        step();
        check("b_bub_valid", b_out_valid, 0);
        check("b_bub_hold",  b_out_data,  8'h55);
        check("b_bub_occ",   b_occ,       0);

        // ---- b: combinational in_ready ----
        drive_b(1'b1, 8'h5A, 1'b1, 1'b0);
        step();
        drive_b(1'b1, 8'h5B, 1'b0, 1'b0);
        #1 check("b_comb_ready0", b_in_ready, 0);
        b_out_ready = 1'b1;
        #1 check("b_comb_ready1", b_in_ready, 1);
        step();
        check("b_pass_5b", b_out_data, 8'h5B);
        check("b_pass_occ", b_occ, 1);

        // ---- b: stall count then flush ----
        drive_b(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("b_stall3", b_stall, 3);
        drive_b(1'b0, '0, 1'b1, 1'b1);
        step();
        b_flush = 1'b0;
        check("b_fl_valid", b_out_valid, 0);
        check("b_fl_hold",  b_out_data,  8'h5B);
        check("b_fl_stall", b_stall,     3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
